second_largest_arbiter: RTL and testbench

//  Shares one second-largest-tracking compare/update datapath between NUM_CH streaming

---
 rtl/second_largest_arbiter.sv | 112 +++++++++++
 tb/tb_second_largest_arbiter.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/second_largest_arbiter.sv
// second_largest_arbiter: round-robin shared largest/second-largest tracker.
// Ports: clk, resetn (sync, active-high); req_valid/req_data/req_ready stream in;
// clr per-channel clear; rd_ch selects rd_first/rd_second/rd_valid readback;
// gnt_valid/gnt_ch report the channel accepted on the previous cycle.
module second_largest_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_CH     = 4,
  parameter int CNT_W      = 8,
  localparam int CH_W      = $clog2(NUM_CH)
) (
  input  logic                         clk,
  input  logic                         resetn,
  input  logic [NUM_CH-1:0]            req_valid,
  input  logic [NUM_CH*DATA_WIDTH-1:0] req_data,
  output logic [NUM_CH-1:0]            req_ready,
  input  logic [NUM_CH-1:0]            clr,
  input  logic [CH_W-1:0]              rd_ch,
  output logic [DATA_WIDTH-1:0]        rd_first,
  output logic [DATA_WIDTH-1:0]        rd_second,
  output logic                         rd_valid,
  output logic                         gnt_valid,
  output logic [CH_W-1:0]              gnt_ch
);

  logic [DATA_WIDTH-1:0] first_q  [NUM_CH];
  logic [DATA_WIDTH-1:0] second_q [NUM_CH];
  logic [CNT_W-1:0]      cnt_q    [NUM_CH];
  logic [DATA_WIDTH-1:0] first_d  [NUM_CH];
  logic [DATA_WIDTH-1:0] second_d [NUM_CH];
  logic [CNT_W-1:0]      cnt_d    [NUM_CH];

  logic [CH_W-1:0]       ptr_q;
  logic [CH_W-1:0]       ptr_d;
  logic [CH_W-1:0]       gnt;
  logic [CH_W-1:0]       idx;
  logic                  found;
  logic                  accept;
  logic [DATA_WIDTH-1:0] din;

  // Search starts at ptr; CH_W-bit add wraps because NUM_CH is a power of two.
  always_comb begin
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    for (int k = 0; k < NUM_CH; k++) begin
      idx = ptr_q + CH_W'(k);
      if (!found && req_valid[idx]) begin
        found = 1'b1;
        gnt   = idx;
      end
    end
  end

  assign accept = found && !resetn;

  always_comb begin
    req_ready = '0;
    if (accept)
      req_ready[gnt] = 1'b1;
  end

  assign din   = req_data[gnt*DATA_WIDTH +: DATA_WIDTH];
  assign ptr_d = accept ? gnt + 1'b1 : ptr_q;

  // Clear is applied before the accepted sample so a colliding
  // sample lands on a freshly zeroed channel.
  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      first_d[i]  = clr[i] ? '0 : first_q[i];
      second_d[i] = clr[i] ? '0 : second_q[i];
      cnt_d[i]    = clr[i] ? '0 : cnt_q[i];
      if (accept && gnt == CH_W'(i)) begin
        if (din >= first_d[i]) begin
          second_d[i] = first_d[i];
          first_d[i]  = din;
        end else if (din >= second_d[i]) begin
          second_d[i] = din;
        end
        if (cnt_d[i] != '1)
          cnt_d[i] = cnt_d[i] + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (resetn) begin
      ptr_q     <= '0;
      gnt_valid <= 1'b0;
      gnt_ch    <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        first_q[i]  <= '0;
        second_q[i] <= '0;
        cnt_q[i]    <= '0;
      end
    end else begin
      ptr_q     <= ptr_d;
      gnt_valid <= accept;
      if (accept)
        gnt_ch  <= gnt;
      for (int i = 0; i < NUM_CH; i++) begin
        first_q[i]  <= first_d[i];
        second_q[i] <= second_d[i];
        cnt_q[i]    <= cnt_d[i];
      end
    end
  end

  assign rd_first  = first_q[rd_ch];
  assign rd_second = second_q[rd_ch];
  assign rd_valid  = cnt_q[rd_ch] >= CNT_W'(2);

endmodule

// File: tb/tb_second_largest_arbiter.sv
// tb_second_largest_arbiter: scoreboard bench for second_largest_arbiter.
// Reference model of per-channel state and round-robin pointer.
module tb_second_largest_arbiter;

  localparam int DW = 32;
  localparam int NC = 4;

  logic           clk = 1'b0;
  logic           resetn;
  logic [NC-1:0]  req_valid;
  logic [NC*DW-1:0] req_data;
  logic [NC-1:0]  req_ready;
  logic [NC-1:0]  clr;
  logic [1:0]     rd_ch;
  logic [DW-1:0]  rd_first;
  logic [DW-1:0]  rd_second;
  logic           rd_valid;
  logic           gnt_valid;
  logic [1:0]     gnt_ch;

  second_largest_arbiter #(.DATA_WIDTH(DW), .NUM_CH(NC), .CNT_W(8)) dut (
    .clk(clk), .resetn(resetn),
    .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
    .clr(clr), .rd_ch(rd_ch),
    .rd_first(rd_first), .rd_second(rd_second), .rd_valid(rd_valid),
    .gnt_valid(gnt_valid), .gnt_ch(gnt_ch)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] m_first  [NC];
  logic [DW-1:0] m_second [NC];
  int            m_cnt    [NC];
  int            m_ptr;
  int            m_wait   [NC];
  logic [2:0]    sb_q [$];

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic int pick(input logic [NC-1:0] v);
    for (int k = 0; k < NC; k++)
      if (v[(m_ptr + k) % NC]) return (m_ptr + k) % NC;
    return -1;
  endfunction

  task automatic model_reset();
    m_ptr = 0;
    for (int i = 0; i < NC; i++) begin
      m_first[i] = '0; m_second[i] = '0; m_cnt[i] = 0; m_wait[i] = 0;
    end
  endtask

  // Called at posedge+1 with inputs already driven; returns at next posedge+1.
  task automatic cycle(input int want_g = -2);
    int g;
    int mx;
    logic [NC-1:0] er;
    logic [DW-1:0] d;
    logic [2:0] e;
    #2;
    g  = resetn ? -1 : pick(req_valid);
    er = (g >= 0) ? NC'(1) << g : '0;
    check("ready", req_ready, er);
    check("onehot", $countones(req_ready) <= 1, 1);
    if (want_g != -2)
      check("rr_order", req_ready, NC'(1) << want_g);
    check("rd_first", rd_first, m_first[rd_ch]);
    check("rd_second", rd_second, m_second[rd_ch]);
    check("rd_valid", rd_valid, m_cnt[rd_ch] >= 2);
    mx = 0;
    for (int i = 0; i < NC; i++) begin
      if (req_valid[i] && !req_ready[i] && !resetn) m_wait[i]++;
      else m_wait[i] = 0;
      if (m_wait[i] > mx) mx = m_wait[i];
    end
    check("starve", mx > NC - 1, 0);
    sb_q.push_back({g >= 0, (g >= 0) ? 2'(g) : 2'd0});
    @(posedge clk);
    if (resetn) begin
      model_reset();
    end else begin
      for (int i = 0; i < NC; i++)
        if (clr[i]) begin
          m_first[i] = '0; m_second[i] = '0; m_cnt[i] = 0;
        end
      if (g >= 0) begin
        d = req_data[g*DW +: DW];
        if (d >= m_first[g]) begin
          m_second[g] = m_first[g];
          m_first[g]  = d;
        end else if (d >= m_second[g]) begin
          m_second[g] = d;
        end
        if (m_cnt[g] < 255) m_cnt[g]++;
        m_ptr = (g + 1) % NC;
      end
    end
    #1;
    e = sb_q.pop_front();
    check("gnt_valid", gnt_valid, e[2]);
    if (e[2]) check("gnt_ch", gnt_ch, e[1:0]);
  endtask

  task automatic drive(input logic [NC-1:0] v, input logic [NC-1:0] c,
                       input logic [1:0] r);
    req_valid = v;
    clr       = c;
    rd_ch     = r;
    for (int i = 0; i < NC; i++) req_data[i*DW +: DW] = $urandom;
  endtask

  logic [DW-1:0] t2_d [5] = '{5, 9, 7, 9, 3};
  logic [DW-1:0] t2_f [5] = '{5, 9, 9, 9, 9};
  logic [DW-1:0] t2_s [5] = '{0, 5, 7, 9, 9};
  int            rr1  [5] = '{1, 2, 3, 0, 1};
  int            rr2  [5] = '{3, 0, 1, 3, 0};

  initial begin
    resetn = 1'b1;
    drive('1, '0, 2'd0);
    model_reset();
    @(posedge clk); #1;
    // T1: reset holds off all grants.
    for (int i = 0; i < 2; i++) begin
      drive('1, '0, 2'(i));
      cycle();
    end
    resetn = 1'b0;
    drive('1, '0, 2'd0);
    cycle(0);
    // T3: round-robin with all valid, then ch2 dropped.
    for (int i = 0; i < 5; i++) begin
      drive('1, '0, 2'(i));
      cycle(rr1[i]);
    end
    for (int i = 0; i < 5; i++) begin
      drive(4'b1011, '0, 2'(i));
      cycle(rr2[i]);
    end
    drive('0, '1, 2'd0);
    cycle();
    // T2: ch1 single stream.
    for (int i = 0; i < 5; i++) begin
      drive(4'b0010, '0, 2'd1);
      req_data[1*DW +: DW] = t2_d[i];
      cycle(1);
      check("t2_first", rd_first, t2_f[i]);
      check("t2_second", rd_second, t2_s[i]);
      check("t2_valid", rd_valid, i >= 1);
    end
    // T4: clear colliding with accept on ch0.
    drive(4'b0001, '0, 2'd0);
    req_data[0 +: DW] = 20;
    cycle(0);
    drive(4'b0001, '0, 2'd0);
    req_data[0 +: DW] = 10;
    cycle(0);
    check("t4_pre_first", rd_first, 20);
    check("t4_pre_second", rd_second, 10);
    drive(4'b0001, 4'b0001, 2'd0);
    req_data[0 +: DW] = 4;
    cycle(0);
    check("t4_first", rd_first, 4);
    check("t4_second", rd_second, 0);
    check("t4_valid", rd_valid, 0);
    // T5: saturation and ties on ch3.
    drive('0, 4'b1000, 2'd3);
    cycle();
    for (int i = 0; i < 300; i++) begin
      drive(4'b1000, '0, 2'd3);
      req_data[3*DW +: DW] = '1;
      cycle(3);
    end
    check("t5_first", rd_first, 32'hFFFF_FFFF);
    check("t5_second", rd_second, 32'hFFFF_FFFF);
    check("t5_valid", rd_valid, 1);
    check("t5_cnt_model", m_cnt[3], 255);
    // T6: random traffic, clears and occasional reset.
    for (int n = 0; n < 10000; n++) begin
      logic [NC-1:0] v, c;
      for (int i = 0; i < NC; i++) begin
        v[i] = $urandom_range(0, 3) != 0;
        c[i] = $urandom_range(0, 31) == 0;
      end
      drive(v, c, 2'($urandom_range(0, 3)));
      if ($urandom_range(0, 7) == 0)
        for (int i = 0; i < NC; i++) req_data[i*DW +: DW] = $urandom_range(0, 7);
      resetn = $urandom_range(0, 999) == 0;
      cycle();
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
